// File: rtl/arbitro_memoria_datos.sv
// arbitro_memoria_datos: two-port round-robin arbiter and sequencer for the shared data RAM.
// One buffered command per port, configurable read latency, registered acks and busy flags.
module arbitro_memoria_datos #(
  parameter int ANCHO_DATOS = 8,
  parameter int ANCHO_DIR   = 8,
  parameter int LATENCIA    = 1
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic                   i_Req0,
  input  logic                   i_Req1,
  input  logic                   i_We0,
  input  logic                   i_We1,
  input  logic [ANCHO_DIR-1:0]   i_Dir0,
  input  logic [ANCHO_DIR-1:0]   i_Dir1,
  input  logic [ANCHO_DATOS-1:0] i_Dato0,
  input  logic [ANCHO_DATOS-1:0] i_Dato1,
  output logic                   o_Ack0,
  output logic                   o_Ack1,
  output logic [ANCHO_DATOS-1:0] o_Dato0,
  output logic [ANCHO_DATOS-1:0] o_Dato1,
  output logic                   o_Ocupado0,
  output logic                   o_Ocupado1,
  output logic                   o_Desborde0,
  output logic                   o_Desborde1,
  output logic                   o_Mem_En,
  output logic                   o_Mem_We,
  output logic [ANCHO_DIR-1:0]   o_Mem_Dir,
  output logic [ANCHO_DATOS-1:0] o_Mem_Dato,
  input  logic [ANCHO_DATOS-1:0] i_Mem_Dato
);
  typedef enum logic [1:0] {IDLE, ACCESO, RESP} estado_t;
  estado_t estado_q, estado_d;
  logic [1:0] req, we_in, acepta, busy;
  logic [1:0] pend_q, pend_d, bwe_q, bwe_d, ack_q, ack_d, ocupado_q, ocupado_d, desborde_q, desborde_d;
  logic [ANCHO_DIR-1:0] dir_in [2], bdir_q [2], bdir_d [2];
  logic [ANCHO_DATOS-1:0] dato_in [2], bdato_q [2], bdato_d [2], rd_q [2], rd_d [2];
  logic [ANCHO_DIR-1:0] mem_dir_q, mem_dir_d;
  logic [ANCHO_DATOS-1:0] mem_dato_q, mem_dato_d;
  logic puerto_q, puerto_d, ultimo_q, ultimo_d, gnt, mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [2:0] cnt_q, cnt_d;

  assign req = {i_Req1, i_Req0};
  assign we_in = {i_We1, i_We0};
  assign dir_in = '{i_Dir0, i_Dir1};
  assign dato_in = '{i_Dato0, i_Dato1};
  assign gnt = &pend_q ? ~ultimo_q : pend_q[1];

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      busy[n] = pend_q[n] | (estado_q != IDLE && puerto_q == 1'(n));
      // the edge that ends a port's RESP cycle may already take its next command
      acepta[n] = req[n] & (~busy[n] | (estado_q == RESP && puerto_q == 1'(n)));
      bwe_d[n] = acepta[n] ? we_in[n] : bwe_q[n];
      bdir_d[n] = acepta[n] ? dir_in[n] : bdir_q[n];
      bdato_d[n] = acepta[n] ? dato_in[n] : bdato_q[n];
    end
    estado_d = estado_q;
    puerto_d = puerto_q;
    ultimo_d = ultimo_q;
    cnt_d = cnt_q;
    pend_d = pend_q;
    rd_d = rd_q;
    mem_en_d = 1'b0;
    mem_we_d = mem_we_q;
    mem_dir_d = mem_dir_q;
    mem_dato_d = mem_dato_q;
    case (estado_q)
      IDLE: if (|pend_q) begin
        estado_d = ACCESO;
        puerto_d = gnt;
        ultimo_d = gnt;
        pend_d[gnt] = 1'b0;
        cnt_d = 3'(LATENCIA);
        mem_en_d = 1'b1;
        mem_we_d = bwe_q[gnt];
        mem_dir_d = bdir_q[gnt];
        mem_dato_d = bdato_q[gnt];
      end
      ACCESO: if (mem_we_q || cnt_q == 3'd0) begin
        estado_d = RESP;
        if (!mem_we_q) rd_d[puerto_q] = i_Mem_Dato;
      end else cnt_d = cnt_q - 3'd1;
      RESP: estado_d = IDLE;
      default: estado_d = IDLE;
    endcase
    pend_d = pend_d | acepta;
    for (int n = 0; n < 2; n++) begin
      ack_d[n] = estado_d == RESP && puerto_d == 1'(n);
      ocupado_d[n] = pend_d[n] | (estado_d != IDLE && puerto_d == 1'(n));
    end
    desborde_d = req & ~acepta;
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      estado_q <= IDLE;
      puerto_q <= 1'b0;
      ultimo_q <= 1'b1;
      cnt_q <= '0;
      pend_q <= '0;
      bwe_q <= '0;
      bdir_q <= '{default: '0};
      bdato_q <= '{default: '0};
      rd_q <= '{default: '0};
      ack_q <= '0;
      ocupado_q <= '0;
      desborde_q <= '0;
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_dir_q <= '0;
      mem_dato_q <= '0;
    end else begin
      estado_q <= estado_d;
      puerto_q <= puerto_d;
      ultimo_q <= ultimo_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      bwe_q <= bwe_d;
      bdir_q <= bdir_d;
      bdato_q <= bdato_d;
      rd_q <= rd_d;
      ack_q <= ack_d;
      ocupado_q <= ocupado_d;
      desborde_q <= desborde_d;
      mem_en_q <= mem_en_d;
      mem_we_q <= mem_we_d;
      mem_dir_q <= mem_dir_d;
      mem_dato_q <= mem_dato_d;
    end
  end

  assign o_Ack0 = ack_q[0];
  assign o_Ack1 = ack_q[1];
  assign o_Dato0 = rd_q[0];
  assign o_Dato1 = rd_q[1];
  assign o_Ocupado0 = ocupado_q[0];
  assign o_Ocupado1 = ocupado_q[1];
  assign o_Desborde0 = desborde_q[0];
  assign o_Desborde1 = desborde_q[1];
  assign o_Mem_En = mem_en_q;
  assign o_Mem_We = mem_we_q;
  assign o_Mem_Dir = mem_dir_q;
  assign o_Mem_Dato = mem_dato_q;
endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// tb_arbitro_memoria_datos: vector table plus hand-written sequences, with a per-port scoreboard
// checked on every acknowledge against a latency-accurate RAM model.
module tb_arbitro_memoria_datos;
  localparam int L = 3;
  logic clk = 0, rst_n = 0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [7:0] dir0 = 0, dir1 = 0, dato0 = 0, dato1 = 0;
  logic ack0, ack1, ocu0, ocu1, des0, des1, mem_en, mem_we;
  logic [7:0] rd0, rd1, mem_dir, mem_dato, mem_rd;
  logic [7:0] ram [256];
  logic [7:0] pipe [L];
  logic loaded = 0;
  int cyc = 0, checks = 0, errors = 0, acks0 = 0, acks1 = 0, desb = 0;
  typedef struct { bit we; logic [7:0] dir; logic [7:0] dato; } sb_t;
  typedef struct { bit p; bit we; logic [7:0] dir; logic [7:0] dato; int lat; } vec_t;
  sb_t q0[$], q1[$];
  bit ack_log[$];
  vec_t tbl [11];
  logic [7:0] last_rd [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  arbitro_memoria_datos #(.ANCHO_DATOS(8), .ANCHO_DIR(8), .LATENCIA(L)) dut (
    .i_Clk(clk), .i_Rst(rst_n),
    .i_Req0(req0), .i_Req1(req1), .i_We0(we0), .i_We1(we1),
    .i_Dir0(dir0), .i_Dir1(dir1), .i_Dato0(dato0), .i_Dato1(dato1),
    .o_Ack0(ack0), .o_Ack1(ack1), .o_Dato0(rd0), .o_Dato1(rd1),
    .o_Ocupado0(ocu0), .o_Ocupado1(ocu1), .o_Desborde0(des0), .o_Desborde1(des1),
    .o_Mem_En(mem_en), .o_Mem_We(mem_we), .o_Mem_Dir(mem_dir), .o_Mem_Dato(mem_dato),
    .i_Mem_Dato(mem_rd)
  );

  // RAM samples at edge E; read data sits on the bus only in the cycle starting at E+L-1
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= (i == 32) ? 8'h3C : 8'(i) ^ 8'hC3;
      loaded <= 1;
    end else if (mem_en && mem_we) ram[mem_dir] <= mem_dato;
    pipe[0] <= (mem_en && !mem_we) ? ram[mem_dir] : 8'hEE;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rd = pipe[L-1];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic sb_pop(input bit p);
    sb_t e;
    if ((p ? q1.size() : q0.size()) == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected_ack%0d: got ack, expected none", p);
      return;
    end
    e = p ? q1.pop_front() : q0.pop_front();
    if (e.we) chk($sformatf("sb_wr%0d_%0h", p, e.dir), ram[e.dir], e.dato);
    else chk($sformatf("sb_rd%0d_%0h", p, e.dir), p ? rd1 : rd0, e.dato);
  endtask

  always @(negedge clk) if (rst_n) begin
    if (des0 || des1) desb++;
    if (ack0) begin acks0++; ack_log.push_back(0); sb_pop(0); end
    if (ack1) begin acks1++; ack_log.push_back(1); sb_pop(1); end
  end

  task automatic arm(input bit p, input bit we, input logic [7:0] dir, input logic [7:0] dato, input bit push);
    if (p) begin req1 = 1; we1 = we; dir1 = dir; dato1 = dato; if (push) q1.push_back('{we, dir, dato}); end
    else begin req0 = 1; we0 = we; dir0 = dir; dato0 = dato; if (push) q0.push_back('{we, dir, dato}); end
  endtask

  task automatic fire;
    @(posedge clk); #1;
    req0 = 0;
    req1 = 0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(input bit p, output int at);
    at = -1;
    for (int i = 0; i < 40 && at < 0; i++) begin
      @(negedge clk);
      if (p ? ack1 : ack0) at = cyc;
    end
    if (at < 0) begin checks++; errors++; $display("FAIL ack_timeout%0d: got no ack, expected one", p); end
  endtask

  task automatic wait_two(output int t0, output int t1);
    t0 = -1;
    t1 = -1;
    for (int i = 0; i < 40 && (t0 < 0 || t1 < 0); i++) begin
      @(negedge clk);
      if (ack0 && t0 < 0) t0 = cyc;
      if (ack1 && t1 < 0) t1 = cyc;
    end
  endtask

  task automatic do_reset;
    @(posedge clk); #2;
    rst_n = 0;
    q0.delete();
    q1.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int k, at, t0, t1, d0, a0;
    tbl = '{
      '{1'b1, 1'b0, 8'h20, 8'h3C, 2+L},
      '{1'b0, 1'b1, 8'h30, 8'h11, 2},
      '{1'b1, 1'b1, 8'h31, 8'h22, 2},
      '{1'b0, 1'b0, 8'h30, 8'h11, 2+L},
      '{1'b1, 1'b0, 8'h31, 8'h22, 2+L},
      '{1'b0, 1'b0, 8'h10, 8'hA5, 2+L},
      '{1'b1, 1'b1, 8'hFF, 8'h80, 2},
      '{1'b0, 1'b0, 8'hFF, 8'h80, 2+L},
      '{1'b1, 1'b0, 8'h00, 8'hC3, 2+L},
      '{1'b0, 1'b1, 8'h20, 8'h5A, 2},
      '{1'b1, 1'b0, 8'h20, 8'h5A, 2+L}
    };
    last_rd = '{8'h00, 8'h00};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {ack0, ack1, rd0, rd1, ocu0, ocu1, des0, des1, mem_en, mem_we, mem_dir, mem_dato}, 64'd0);
    step;
    rst_n = 1;
    while (cyc < 4) step;

    arm(0, 1, 8'h10, 8'hA5, 1);
    fire;
    k = cyc;
    @(negedge clk); chk("w0_cycle_k", {ocu0, mem_en}, 2'b10);
    @(negedge clk); chk("w0_mem_bus", {mem_en, mem_we, mem_dir, mem_dato, ocu0}, {1'b1, 1'b1, 8'h10, 8'hA5, 1'b1});
    @(negedge clk); chk("w0_ack", {ack0, ocu0, mem_en}, 3'b110);
    @(negedge clk); chk("w0_done", {ack0, ocu0}, 2'b00);

    foreach (tbl[i]) begin
      step;
      arm(tbl[i].p, tbl[i].we, tbl[i].dir, tbl[i].dato, 1);
      fire;
      k = cyc;
      wait_ack(tbl[i].p, at);
      chk($sformatf("lat_v%0d", i), at - k, tbl[i].lat);
      if (!tbl[i].we) begin
        chk($sformatf("rd_v%0d", i), tbl[i].p ? rd1 : rd0, tbl[i].dato);
        last_rd[tbl[i].p] = tbl[i].dato;
      end
      chk($sformatf("other_rd_v%0d", i), tbl[i].p ? rd0 : rd1, last_rd[~tbl[i].p]);
      @(negedge clk);
      chk($sformatf("ocupado_off_v%0d", i), tbl[i].p ? ocu1 : ocu0, 1'b0);
    end

    do_reset;
    step;
    arm(0, 1, 8'h40, 8'h01, 1);
    arm(1, 1, 8'h41, 8'h02, 1);
    fire;
    k = cyc;
    wait_two(t0, t1);
    chk("tie1_p0_first", t0 - k, 2);
    chk("tie1_p1_next", t1 - k, 5);
    step;
    arm(0, 1, 8'h42, 8'h03, 1);
    fire;
    wait_ack(0, at);
    step;
    arm(0, 1, 8'h43, 8'h04, 1);
    arm(1, 1, 8'h44, 8'h05, 1);
    fire;
    k = cyc;
    wait_two(t0, t1);
    chk("tie2_p1_first", t1 - k, 2);
    chk("tie2_p0_next", t0 - k, 5);

    step;
    ack_log.delete();
    d0 = desb;
    fork
      begin
        int a;
        for (int n = 0; n < 4; n++) begin
          arm(0, 1, 8'h50 + 8'(n), 8'h60 + 8'(n), 1);
          @(posedge clk); #1;
          req0 = 0;
          wait_ack(0, a);
        end
      end
      begin
        int b;
        for (int m = 0; m < 4; m++) begin
          arm(1, 1, 8'h58 + 8'(m), 8'h68 + 8'(m), 1);
          @(posedge clk); #1;
          req1 = 0;
          wait_ack(1, b);
        end
      end
    join
    step;
    chk("burst_acks", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size(); i++) chk($sformatf("burst_order%0d", i), ack_log[i], (i % 2 == 0) ? 1 : 0);
    chk("burst_no_desborde", desb - d0, 0);

    step;
    d0 = desb;
    arm(0, 1, 8'h70, 8'h77, 1);
    fire;
    k = cyc;
    arm(0, 1, 8'h71, 8'h99, 0);
    fire;
    @(negedge clk); chk("desborde0_pulse", {des0, ocu0}, 2'b11);
    @(negedge clk); chk("ack0_after_drop", {ack0, des0}, 2'b10);
    arm(0, 1, 8'h72, 8'h55, 1);
    fire;
    @(negedge clk); chk("b2b_accept", {ocu0, des0, mem_en, ack0}, 4'b1000);
    @(negedge clk); chk("b2b_grant", {mem_en, mem_dir, mem_dato}, {1'b1, 8'h72, 8'h55});
    wait_ack(0, at);
    chk("b2b_lat", at - k, 5);
    step;
    chk("drop_no_write", ram[8'h71], 8'hB2);
    chk("desborde_once", desb - d0, 1);

    step;
    arm(0, 0, 8'h30, 8'h11, 1);
    fire;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_async_outs", {ack0, ack1, rd0, rd1, ocu0, ocu1, des0, des1, mem_en, mem_we, mem_dir, mem_dato}, 64'd0);
    q0.delete();
    q1.delete();
    a0 = acks0 + acks1;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    repeat (10) @(negedge clk);
    step;
    chk("no_ack_after_abort", acks0 + acks1 - a0, 0);
    arm(0, 0, 8'h31, 8'h22, 1);
    fire;
    k = cyc;
    wait_ack(0, at);
    chk("post_rst_lat", at - k, 2 + L);
    chk("post_rst_rd", rd0, 8'h22);
    step;
    chk("sb_empty", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/arbitro_memoria_datos.md
# arbitro_memoria_datos

Two-port arbiter and sequencer for the 8-bit data memory. It shares one synchronous RAM port between the processor's data interface and a second requester (program/data loader or debug port). It buffers one command per port, grants round-robin, sequences the access with a configurable read latency, and returns a one-cycle acknowledge with read data. It also provides a per-port busy flag used to stall the processor.

## Interface
- ANCHO_DATOS, 8, data width
- ANCHO_DIR, 8, address width
- LATENCIA, 1, RAM read latency in cycles (legal 1..4)

- i_Clk  in  1  clock, rising edge
- i_Rst  in  1  asynchronous, active-low reset
- i_Req0 / i_Req1  in  1  single-cycle command pulse, port 0 (processor) / port 1 (loader)
- i_We0 / i_We1  in  1  1 = write, 0 = read; sampled with Req
- i_Dir0 / i_Dir1  in  ANCHO_DIR  address; sampled with Req
- i_Dato0 / i_Dato1  in  ANCHO_DATOS  write data; sampled with Req
- o_Ack0 / o_Ack1  out  1  one-cycle completion pulse
- o_Dato0 / o_Dato1  out  ANCHO_DATOS  read data; valid while Ack is high, held until next read on that port
- o_Ocupado0 / o_Ocupado1  out  1  port has a buffered or in-service command
- o_Desborde0 / o_Desborde1  out  1  one-cycle pulse: Req dropped because port busy
- o_Mem_En  out  1  RAM access strobe, one cycle per access
- o_Mem_We  out  1  RAM write enable, qualified by o_Mem_En
- o_Mem_Dir  out  ANCHO_DIR  RAM address
- o_Mem_Dato  out  ANCHO_DATOS  RAM write data
- i_Mem_Dato  in  ANCHO_DATOS  RAM read data

## Operation
- Per port: one-entry buffer {We, Dir, Dato} plus pending bit. Req sampled at an edge loads the buffer and sets pending.
- Req is accepted only if the port is not busy. A Req sampled at the edge that ends that port's Ack cycle is accepted (back-to-back). Any other Req while busy is dropped and pulses Desborde the next cycle. Buffer contents are not modified.
- Busy = pending, or port in service (ACCESO or RESP for that port). o_Ocupado equals busy, registered.
- FSM states are IDLE, ACCESO, RESP.
  - IDLE: if any pending, grant and go to ACCESO. Copy the winner's buffer to the RAM outputs, clear its pending, and record it in `ultimo`.
  - Both pending: grant the port that is not `ultimo`.
  - ACCESO: o_Mem_En is high only in the first ACCESO cycle. Write goes to RESP next edge. Read loads a counter with LATENCIA and decrements it each ACCESO cycle. When the counter reaches 0, i_Mem_Dato is captured into o_DatoN and the FSM goes to RESP.
  - RESP: o_AckN high for exactly this cycle, then IDLE.
- o_Mem_Dir, o_Mem_Dato and o_Mem_We hold their values from grant until the next grant.
- RAM contract: the RAM samples En/We/Dir/Dato at an edge E. Read data is valid in the cycle starting at edge E+LATENCIA-1.
- Pending requests stay queued during an access. A port never waits more than one other access (round-robin, one entry per port).

## Timing
- Reset (async, i_Rst=0) forces, immediately and regardless of state:
  - FSM to IDLE, pending bits to 0, counter to 0, `ultimo` to port 1 (so port 0 wins the first tie).
  - Every output to 0.
- A reset mid-access aborts the access: no Ack is produced and the buffered commands are lost.
- Req sampled at edge k, FSM idle:
  - Grant at edge k+1; o_Mem_En high in cycle [k+1,k+2).
  - Write: Ack high in cycle [k+2,k+3), 2-cycle latency.
  - Read: data captured at edge k+1+LATENCIA+1; Ack high in cycle [k+2+LATENCIA, k+3+LATENCIA).
- Throughput: a write takes 3 cycles IDLE→IDLE, a read takes 3+LATENCIA cycles.
- o_Ocupado rises at edge k and falls at the edge ending Ack, unless a back-to-back Req is accepted there.
- Simultaneous Req0 and Req1 at the same edge: both buffered, the tie is served by round-robin.

## Test plan
- Reset then single write port 0 (Req0 at edge 5, Dir=0x10, Dato=0xA5) -> o_Mem_En=1, o_Mem_We=1, o_Mem_Dir=0x10 in cycle 6; o_Ack0 in cycle 7; o_Ocupado0 high cycles 5–7.
- Read port 1, LATENCIA=3, RAM model returns 0x3C from addr 0x20 -> o_Ack1 in cycle k+5 with o_Dato1=0x3C; o_Dato0 unchanged.
- Req0 and Req1 at same edge after reset -> port 0 served first, port 1 immediately after. Repeat the tie -> port 1 first (alternation).
- Second Req0 during its own ACCESO -> dropped, o_Desborde0 pulses once, original access completes. Req0 at the edge ending Ack -> accepted, granted next cycle.
- Continuous writes on both ports at maximum rate -> strict alternation, every access gets one Ack, no Desborde.
- Assert i_Rst mid-read (ACCESO) -> all outputs 0 immediately, no Ack after release. A new read after release completes normally.
